// File: rtl/lock_button_conditioner.sv
// Two-button synchroniser, debouncer and press-pulse arbiter.
// Emits one-cycle, mutually exclusive press pulses for the lock FSM.
module lock_button_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  localparam int CNT_W      = $clog2(DB_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn0_raw,
  input  logic btn1_raw,
  output logic but_0,
  output logic but_1,
  output logic btn_err
);

  typedef enum logic [1:0] {
    REL,
    REL_CHK,
    PRS,
    PRS_CHK
  } st_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync [2];
  logic                   raw  [2];
  logic                   s_n  [2];

  st_t              st     [2];
  st_t              st_nx  [2];
  logic [CNT_W-1:0] cnt    [2];
  logic [CNT_W-1:0] cnt_nx [2];
  logic             ev     [2];
  logic             prs    [2];

  assign raw[0] = btn0_raw;
  assign raw[1] = btn1_raw;

  // Raw pins feed the first flop directly; nothing in front of it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync[0] <= '0;
      sync[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], raw[i]};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      s_n[i]    = sync[i][SYNC_STAGES-1];
      prs[i]    = (st[i] == PRS) || (st[i] == PRS_CHK);
      st_nx[i]  = st[i];
      cnt_nx[i] = cnt[i];
      ev[i]     = 1'b0;
      unique case (st[i])
        REL: begin
          if (s_n[i]) begin
            st_nx[i]  = REL_CHK;
            cnt_nx[i] = ONE;
          end else begin
            cnt_nx[i] = '0;
          end
        end
        REL_CHK: begin
          if (!s_n[i]) begin
            st_nx[i]  = REL;
            cnt_nx[i] = '0;
          end else if (cnt[i] == LAST) begin
            st_nx[i]  = PRS;
            cnt_nx[i] = '0;
            ev[i]     = 1'b1;
          end else begin
            cnt_nx[i] = cnt[i] + ONE;
          end
        end
        PRS: begin
          if (!s_n[i]) begin
            st_nx[i]  = PRS_CHK;
            cnt_nx[i] = ONE;
          end else begin
            cnt_nx[i] = '0;
          end
        end
        PRS_CHK: begin
          if (s_n[i]) begin
            st_nx[i]  = PRS;
            cnt_nx[i] = '0;
          end else if (cnt[i] == LAST) begin
            st_nx[i]  = REL;
            cnt_nx[i] = '0;
          end else begin
            cnt_nx[i] = cnt[i] + ONE;
          end
        end
        default: begin
          st_nx[i]  = REL;
          cnt_nx[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st[0]   <= REL;
      st[1]   <= REL;
      cnt[0]  <= '0;
      cnt[1]  <= '0;
      but_0   <= 1'b0;
      but_1   <= 1'b0;
      btn_err <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= st_nx[i];
        cnt[i] <= cnt_nx[i];
      end
      // A press while the other button is held, or a tie, is rejected.
      but_0   <= ev[0] && !ev[1] && !prs[1];
      but_1   <= ev[1] && !ev[0] && !prs[0];
      btn_err <= (ev[0] && ev[1]) ||
                 (ev[0] && prs[1]) ||
                 (ev[1] && prs[0]);
    end
  end

endmodule

// File: doc/lock_button_conditioner.md
Name: lock_button_conditioner

Overview:
- Front-end stage that sits directly upstream of the electronic combination lock FSM.
- Takes two raw, asynchronous, bouncing push-button inputs and synchronises and debounces them.
- Emits one-cycle, mutually exclusive press pulses on but_0/but_1, which connect directly to the lock's inputs of the same name.
- Guarantees one physical press produces exactly one lock-FSM step, never a held level or a two-button overlap.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per raw input; legal range 2..4.
- DB_CYCLES, 16, consecutive identical synchronised samples required to accept a level change; legal range 2..65535.
- CNT_W, $clog2(DB_CYCLES+1), width of each debounce counter; derived, not overridden.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- btn0_raw  input  1  raw button 0, asynchronous to CLK, active-high, may bounce.
- btn1_raw  input  1  raw button 1, asynchronous to CLK, active-high, may bounce.
- but_0  output  1  registered one-cycle press pulse for button 0.
- but_1  output  1  registered one-cycle press pulse for button 1.
- btn_err  output  1  registered one-cycle pulse; a press was rejected because of a two-button overlap.

Behaviour:
- Reset (RESET=0, asynchronous): all synchroniser flops are 0, both FSMs are in REL, both counters are 0, and but_0=but_1=btn_err=0. A reset mid-count or mid-press discards all progress. After release, a still-held button is seen as a new press and must complete the full debounce.
- Synchroniser: each raw input passes through a SYNC_STAGES-deep flop chain. sN is the last stage. No logic is allowed on the raw inputs before the first flop.
- Per-button FSM (identical, independent), states REL, REL_CHK, PRS, PRS_CHK:
  - REL: sN=1 -> REL_CHK with cnt=1; otherwise stay, cnt=0.
  - REL_CHK: sN=0 -> REL, cnt=0. sN=1 and cnt==DB_CYCLES-1 -> PRS, cnt=0, raise press event. Otherwise cnt+1.
  - PRS: sN=0 -> PRS_CHK with cnt=1; otherwise stay.
  - PRS_CHK: sN=1 -> PRS, cnt=0. sN=0 and cnt==DB_CYCLES-1 -> REL, cnt=0, no event. Otherwise cnt+1.
  - The counter never exceeds DB_CYCLES-1 and does not wrap.
- Latency: raw held high from before edge 1 -> press event at edge SYNC_STAGES+DB_CYCLES. The pulse is visible for exactly the following cycle. Releases produce no output.
- Arbitration, evaluated each edge on the press events:
  - Event on button N only, and the other FSM is in REL or REL_CHK -> but_N=1 for one cycle.
  - Event on button N only, and the other FSM is in PRS or PRS_CHK -> pulse suppressed, btn_err=1 for one cycle.
  - Events on both buttons at the same edge -> both suppressed, btn_err=1 for one cycle.
- Invariants:
  - but_0 & but_1 is never 1.
  - btn_err is never 1 in the same cycle as but_0 or but_1.
  - Every output pulse is exactly one cycle wide.
  - No further pulse on a button until it has debounced to REL and pressed again.
- Holding a button indefinitely produces a single pulse; there is no auto-repeat.
- A bounce shorter than DB_CYCLES samples, in either direction, resets that FSM's count and returns it to the stable state it was checking from.

Test Plan (SYNC_STAGES=2, DB_CYCLES=4):
- Clean press of btn0_raw held 20 cycles from before edge 1 -> but_0=1 only in the cycle after edge 6; but_1=btn_err=0 throughout; release produces nothing.
- btn1_raw bounces 1,0,1,1,0,1 then holds high -> no pulse until 4 consecutive sN=1 samples; then exactly one but_1 pulse, exactly 6 edges after the final stable rise.
- btn0 held (PRS), then btn1 pressed and held -> btn1 event suppressed; btn_err=1 for one cycle; but_1 stays 0.
- btn0_raw and btn1_raw rise on the same cycle -> btn_err=1 once after edge 6; but_0=but_1=0.
- btn0 held, RESET pulsed low at cycle 4 mid-count, raw still high -> outputs 0 immediately; after deassertion, one but_0 pulse exactly 6 edges later.
- Sequence 0,1,0,1,1 of clean presses separated by 10-cycle releases -> pulses but_0,but_1,but_0,but_1,but_1 in order, one each; driving the lock with these yields UNLOCK=1.
